// File: rtl/sw_feeder.sv
// rtl/sw_feeder.sv - streams two host-loaded symbol buffers to the aligner and captures its score
// A run replays both buffers once, then waits a bounded time for the aligner's finish pulse.
module sw_feeder #(
  parameter int LEN     = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              start,
  input  logic              result_ack,
  input  logic              finish,
  input  logic [11:0]       max,
  output logic              valid,
  output logic [1:0]        data_s,
  output logic [1:0]        data_t,
  output logic              busy,
  output logic              result_valid,
  output logic [11:0]       result,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] s_buf [LEN];
  logic [1:0] t_buf [LEN];

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, idx_inc;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              valid_n, busy_n, rv_n, to_n;
  logic [1:0]        ds_n, dt_n;
  logic [11:0]       res_n;

  // Buffers are host-owned storage: no reset, so contents survive runs and resets.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && !start) begin
      if (wr_sel) t_buf[wr_addr] <= wr_data;
      else        s_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      valid        <= 1'b0;
      data_s       <= 2'd0;
      data_t       <= 2'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= 12'd0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      valid        <= valid_n;
      data_s       <= ds_n;
      data_t       <= dt_n;
      busy         <= busy_n;
      result_valid <= rv_n;
      result       <= res_n;
      timeout      <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    valid_n = valid;
    ds_n    = data_s;
    dt_n    = data_t;
    rv_n    = result_valid;
    res_n   = result;
    to_n    = timeout;
    idx_inc = idx + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          idx_n   = '0;
          valid_n = 1'b1;
          ds_n    = s_buf[0];
          dt_n    = t_buf[0];
          to_n    = 1'b0;
        end
      end
      SEND: begin
        if (idx == IDX_LAST) begin
          state_n = WAIT;
          idx_n   = '0;
          cnt_n   = '0;
          valid_n = 1'b0;
          ds_n    = 2'd0;
          dt_n    = 2'd0;
        end else begin
          idx_n = idx_inc;
          ds_n  = s_buf[idx_inc];
          dt_n  = t_buf[idx_inc];
        end
      end
      WAIT: begin
        // finish is checked first so it wins a tie with the timeout edge
        if (finish) begin
          state_n = DONE;
          res_n   = max;
          rv_n    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = DONE;
          res_n   = 12'd0;
          rv_n    = 1'b1;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (result_ack) begin
          state_n = IDLE;
          rv_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sw_feeder.sv
// tb/tb_sw_feeder.sv - directed scoreboard bench for sw_feeder
module tb_sw_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_addr = 8'd0;
  logic [1:0] wr_data = 2'd0;
  logic       start = 1'b0;
  logic       result_ack = 1'b0;
  logic       finish = 1'b0;
  logic [11:0] max = 12'd0;
  logic       valid;
  logic [1:0] data_s, data_t;
  logic       busy, result_valid, timeout;
  logic [11:0] result;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  logic [3:0] q[$];
  logic [1:0] ms [256];
  logic [1:0] mt [256];

  sw_feeder #(.LEN(256), .ADDR_W(8), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .result_ack(result_ack), .finish(finish),
    .max(max), .valid(valid), .data_s(data_s), .data_t(data_t), .busy(busy),
    .result_valid(result_valid), .result(result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [7:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) mt[a] = d; else ms[a] = d;
  endtask

  task automatic push_run();
    for (int i = 0; i < 256; i++) q.push_back({ms[i], mt[i]});
  endtask

  task automatic drain_stream(input string tag);
    int n;
    n = 0;
    while (valid === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_len"}, vcount, 256);
    check({tag, "_qempty"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      if (q.size() == 0) check("extra_valid", 1, 0);
      else check("sym", {data_s, data_t}, q.pop_front());
    end
  end

  initial begin
    #12;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_timeout", timeout, 0);
    check("rst_data", {data_s, data_t}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) begin
      wr(1'b0, 8'(i), 2'(i % 4));
      wr(1'b1, 8'(i), 2'(3 - (i % 4)));
    end

    // run 1: normal finish, then long hold before ack
    vcount = 0; push_run();
    start = 1'b1; tick(); start = 1'b0;
    check("r1_busy", busy, 1);
    drain_stream("r1");
    repeat (19) tick();
    finish = 1'b1; max = 12'd37; tick(); finish = 1'b0; max = 12'd0;
    check("r1_result", result, 37);
    check("r1_rv", result_valid, 1);
    check("r1_timeout", timeout, 0);
    repeat (50) tick();
    check("r1_hold_result", result, 37);
    check("r1_hold_rv", result_valid, 1);
    check("r1_hold_busy", busy, 1);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("r1_ack_rv", result_valid, 0);
    check("r1_ack_busy", busy, 0);
    check("r1_keep_result", result, 37);

    // finish and ack in IDLE are ignored
    finish = 1'b1; result_ack = 1'b1; tick(); finish = 1'b0; result_ack = 1'b0;
    check("idle_finish_busy", busy, 0);
    check("idle_finish_rv", result_valid, 0);

    // run 2: replay, finish during SEND ignored, then timeout
    vcount = 0; push_run();
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    finish = 1'b1; tick(); finish = 1'b0;
    drain_stream("r2");
    repeat (10) tick();
    check("r2_wait_busy", busy, 1);
    check("r2_wait_rv", result_valid, 0);
    check("r2_wait_result", result, 37);
    repeat (1012) tick();
    check("r2_pre_to_rv", result_valid, 0);
    check("r2_pre_to_flag", timeout, 0);
    tick();
    check("r2_to_flag", timeout, 1);
    check("r2_to_rv", result_valid, 1);
    check("r2_to_result", result, 0);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("r2_ack_busy", busy, 0);

    // run 3: writes with start and during SEND dropped; finish ties timeout
    vcount = 0; push_run();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = ~ms[0];
    start = 1'b1; tick(); start = 1'b0; wr_en = 1'b0;
    check("r3_timeout_clr", timeout, 0);
    repeat (3) tick();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 8'd200; wr_data = ~mt[200];
    tick(); wr_en = 1'b0;
    drain_stream("r3");
    repeat (1022) tick();
    finish = 1'b1; max = 12'd99; tick(); finish = 1'b0; max = 12'd0;
    check("r3_tie_result", result, 99);
    check("r3_tie_timeout", timeout, 0);
    check("r3_tie_rv", result_valid, 1);
    result_ack = 1'b1; tick(); result_ack = 1'b0;

    // run 4: reset aborts at index 100, then a fresh run from index 0
    vcount = 0; push_run();
    start = 1'b1; tick(); start = 1'b0;
    repeat (100) tick();
    check("r4_pre_rst_valid", valid, 1);
    check("r4_idx100", {data_s, data_t}, {ms[100], mt[100]});
    #1 reset = 1'b1;
    #1;
    check("r4_async_valid", valid, 0);
    check("r4_async_busy", busy, 0);
    q.delete();
    tick();
    reset = 1'b0;
    tick();
    check("r4_post_busy", busy, 0);
    check("r4_post_valid", valid, 0);
    check("r4_post_result", result, 0);
    vcount = 0; push_run();
    start = 1'b1; tick(); start = 1'b0;
    drain_stream("r5");
    finish = 1'b1; max = 12'd5; tick(); finish = 1'b0;
    check("r5_result", result, 5);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("r5_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "bench time limit");
  end

endmodule
